// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment bus capture path.
// Segment patterns are active-low in gfedcba order; the anode bus is active-low.
package display_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0]  AN_NONE  = 4'hF;
   localparam logic [11:0] IDLE_BUS = {4'hF, 8'hFF};

   // an[3] drives digit_1 (leftmost), an[0] drives digit_4
   localparam logic [1:0] POS_DIGIT_1 = 2'd3;
   localparam logic [1:0] POS_DIGIT_2 = 2'd2;
   localparam logic [1:0] POS_DIGIT_3 = 2'd1;
   localparam logic [1:0] POS_DIGIT_4 = 2'd0;

   typedef struct packed {
      logic       legal;
      logic       is_blank;
      logic [3:0] value;
   } seg_dec_t;

   typedef enum logic [1:0] {
      AN_IDLE,
      AN_ONE,
      AN_MULTI
   } an_class_t;

   function automatic an_class_t classify_an(input logic [3:0] an);
      int lows;
      lows = $countones(~an);
      if (lows == 0)      return AN_IDLE;
      else if (lows == 1) return AN_ONE;
      else                return AN_MULTI;
   endfunction

   function automatic logic [1:0] an_pos(input logic [3:0] an);
      logic [1:0] p;
      p = 2'd0;
      for (int i = 0; i < 4; i++)
         if (!an[i]) p = 2'(i);
      return p;
   endfunction

endpackage

// File: rtl/display_capture_if.sv
// Multiplexed seven-segment bus plus the reconstructed display readback.
interface display_capture_if;
   logic [7:0] seg;
   logic [3:0] an;
   logic [3:0] digit_1;
   logic [3:0] digit_2;
   logic [3:0] digit_3;
   logic [3:0] digit_4;
   logic [3:0] digit_valid;
   logic [3:0] blank;
   logic       frame_done;
   logic       err_anode;
   logic       err_seg;

   modport master (
      output seg, an,
      input  digit_1, digit_2, digit_3, digit_4,
      input  digit_valid, blank, frame_done, err_anode, err_seg
   );

   modport slave (
      input  seg, an,
      output digit_1, digit_2, digit_3, digit_4,
      output digit_valid, blank, frame_done, err_anode, err_seg
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment pattern decoder.
module seg7_decode
   import display_pkg::*;
(
   input  logic [6:0] pattern,
   output seg_dec_t   dec
);

   always_comb begin
      dec = '0;
      case (pattern)
         SEG_0:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd0};
         SEG_1:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd1};
         SEG_2:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd2};
         SEG_3:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd3};
         SEG_4:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd4};
         SEG_5:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd5};
         SEG_6:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd6};
         SEG_7:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd7};
         SEG_8:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd8};
         SEG_9:     dec = '{legal: 1'b1, is_blank: 1'b0, value: 4'd9};
         SEG_BLANK: dec = '{legal: 1'b1, is_blank: 1'b1, value: 4'd0};
         default:   dec = '0;
      endcase
   end

endmodule

// File: rtl/display_capture.sv
// Reconstructs the four displayed digits from the multiplexed seg/an bus,
// accepting a bus value only after it has been stable for STABLE_CYCLES samples.
module display_capture
   import display_pkg::*;
#(
   parameter int STABLE_CYCLES = 64
) (
   input logic              master_clk,
   input logic              rst,
   display_capture_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

   logic [11:0]      sample;
   logic [11:0]      s_reg;
   logic [CW-1:0]    cnt;
   logic             same;
   logic             accept;

   seg_dec_t         dec;
   an_class_t        an_cls;
   logic [1:0]       pos;
   logic [3:0]       seen;
   logic [3:0]       seen_next;

   logic [3:0][3:0]  digits;
   logic [3:0]       digit_valid;
   logic [3:0]       blank;
   logic             frame_done;
   logic             err_anode;
   logic             err_seg;

   assign sample = {bus.an, bus.seg};
   assign same   = (sample == s_reg);
   // cnt saturates, so the accept compare can only match once per phase
   assign accept = same && (cnt == CNT_ACC);

   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         s_reg <= IDLE_BUS;
         cnt   <= '0;
      end else begin
         s_reg <= sample;
         if (!same)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   seg7_decode u_decode (
      .pattern (bus.seg[6:0]),
      .dec     (dec)
   );

   always_comb begin
      an_cls    = classify_an(bus.an);
      pos       = an_pos(bus.an);
      seen_next = seen | (4'b0001 << pos);
   end

   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         digits      <= '0;
         digit_valid <= '0;
         blank       <= '0;
         seen        <= '0;
         frame_done  <= 1'b0;
         err_anode   <= 1'b0;
         err_seg     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err_anode  <= 1'b0;
         err_seg    <= 1'b0;
         if (accept) begin
            case (an_cls)
               AN_MULTI: err_anode <= 1'b1;
               AN_ONE: begin
                  if (!dec.legal) begin
                     err_seg <= 1'b1;
                  end else begin
                     if (dec.is_blank) begin
                        blank[pos] <= 1'b1;
                     end else begin
                        digits[pos]      <= dec.value;
                        digit_valid[pos] <= 1'b1;
                        blank[pos]       <= 1'b0;
                     end
                     // a completed mask reports the frame and starts the next one
                     if (seen_next == 4'hF) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                     end else begin
                        seen <= seen_next;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.digit_1     = digits[POS_DIGIT_1];
   assign bus.digit_2     = digits[POS_DIGIT_2];
   assign bus.digit_3     = digits[POS_DIGIT_3];
   assign bus.digit_4     = digits[POS_DIGIT_4];
   assign bus.digit_valid = digit_valid;
   assign bus.blank       = blank;
   assign bus.frame_done  = frame_done;
   assign bus.err_anode   = err_anode;
   assign bus.err_seg     = err_seg;

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: directed phases with literal expectations, then random
// bus phases, all cross-checked every cycle against a phase-level reference model.
module tb_display_capture;

   localparam int S = 64;

   logic master_clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   display_capture_if bus ();

   display_capture #(.STABLE_CYCLES(S)) dut (
      .master_clk (master_clk),
      .rst        (rst),
      .bus        (bus)
   );

   always #5 master_clk = ~master_clk;

   logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // reference model state; index 3 is digit_1
   int         m_dig [4];
   logic [3:0] m_valid = '0;
   logic [3:0] m_blank = '0;
   logic [3:0] m_seen  = '0;
   logic       m_fd = 1'b0, m_ea = 1'b0, m_es = 1'b0;
   logic [11:0] last_in;
   bit         have_last = 0;
   int         run = 0;

   int fd_cnt = 0, ea_cnt = 0, es_cnt = 0;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_dig[k] = 0;
      m_valid = '0; m_blank = '0; m_seen = '0;
      m_fd = 0; m_ea = 0; m_es = 0;
      have_last = 0; run = 0;
   endtask

   task automatic model_accept(input logic [3:0] a, input logic [6:0] s);
      int lows, p, val;
      lows = $countones(~a);
      if (lows > 1) begin
         m_ea = 1;
      end else if (lows == 1) begin
         p = 0;
         for (int k = 0; k < 4; k++) if (!a[k]) p = k;
         val = -1;
         for (int k = 0; k < 10; k++) if (s == pat[k]) val = k;
         if (s == 7'h7F) begin
            m_blank[p] = 1;
         end else if (val < 0) begin
            m_es = 1;
            return;
         end else begin
            m_dig[p] = val; m_valid[p] = 1; m_blank[p] = 0;
         end
         m_seen[p] = 1;
         if (m_seen == 4'hF) begin
            m_fd = 1;
            m_seen = '0;
         end
      end
   endtask

   // A value is taken on the (S+1)-th consecutive edge it is sampled
   initial begin
      model_reset();
      forever begin
         @(posedge master_clk or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            m_fd = 0; m_ea = 0; m_es = 0;
            if (have_last && {bus.an, bus.seg} == last_in) begin
               if (run < S + 2) run++;
            end else begin
               run = 1;
            end
            have_last = 1;
            last_in = {bus.an, bus.seg};
            if (run == S + 1) model_accept(bus.an, bus.seg[6:0]);
         end
      end
   end

   initial begin
      forever begin
         @(negedge master_clk);
         total++;
         if (bus.digit_1 !== 4'(m_dig[3]) || bus.digit_2 !== 4'(m_dig[2]) ||
             bus.digit_3 !== 4'(m_dig[1]) || bus.digit_4 !== 4'(m_dig[0]) ||
             bus.digit_valid !== m_valid || bus.blank !== m_blank ||
             bus.frame_done !== m_fd || bus.err_anode !== m_ea || bus.err_seg !== m_es) begin
            bad++;
            $display("FAIL model t=%0t got dig=%h%h%h%h v=%b b=%b fd=%b ea=%b es=%b want dig=%0d%0d%0d%0d v=%b b=%b fd=%b ea=%b es=%b",
                     $time, bus.digit_1, bus.digit_2, bus.digit_3, bus.digit_4, bus.digit_valid,
                     bus.blank, bus.frame_done, bus.err_anode, bus.err_seg,
                     m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, m_blank, m_fd, m_ea, m_es);
         end
         if (bus.frame_done === 1'b1) fd_cnt++;
         if (bus.err_anode === 1'b1) ea_cnt++;
         if (bus.err_seg === 1'b1) es_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic phase(input logic [3:0] a, input logic [7:0] s, input int n);
      bus.an  = a;
      bus.seg = s;
      repeat (n) @(posedge master_clk);
      #2;
   endtask

   function automatic logic [15:0] digs();
      return {bus.digit_1, bus.digit_2, bus.digit_3, bus.digit_4};
   endfunction

   int fd0, ea0, es0;

   initial begin
      rst = 1'b1;
      bus.an = 4'hF;
      bus.seg = 8'hFF;
      repeat (3) @(posedge master_clk);
      #2 rst = 1'b0;
      check("reset_digits", 32'(digs()), 32'h0);
      check("reset_valid", 32'(bus.digit_valid), 32'h0);
      check("reset_blank", 32'(bus.blank), 32'h0);

      // first capture lands on the (S+1)-th sampled edge
      phase(4'b0111, 8'h99, S);
      check("not_yet_valid", 32'(bus.digit_valid), 32'h0);
      phase(4'b0111, 8'h99, 1);
      check("first_valid", 32'(bus.digit_valid), 32'h8);
      check("first_digit", 32'(bus.digit_1), 32'h4);
      phase(4'b0111, 8'h99, 20);

      fd0 = fd_cnt;
      phase(4'b0111, {1'b1, 7'h19}, 100);
      phase(4'b1011, {1'b1, 7'h02}, 100);
      phase(4'b1101, {1'b1, 7'h00}, 100);
      check("no_frame_yet", 32'(fd_cnt - fd0), 32'd0);
      phase(4'b1110, {1'b1, 7'h10}, 100);
      check("frame_once", 32'(fd_cnt - fd0), 32'd1);
      check("four_digits", 32'(digs()), 32'h4689);
      check("all_valid", 32'(bus.digit_valid), 32'hF);

      phase(4'b0111, {1'b1, 7'h7F}, 100);
      check("blank_set", 32'(bus.blank), 32'h8);
      check("blank_keeps", 32'(bus.digit_1), 32'h4);
      phase(4'b0111, {1'b1, 7'h40}, 100);
      check("blank_clr", 32'(bus.blank), 32'h0);
      check("zero_digit", 32'(bus.digit_1), 32'h0);

      ea0 = ea_cnt;
      es0 = es_cnt;
      phase(4'b0011, {1'b1, 7'h19}, 100);
      check("err_anode_once", 32'(ea_cnt - ea0), 32'd1);
      check("err_anode_hold", 32'(digs()), 32'h0689);
      phase(4'b1110, {1'b1, 7'h7E}, 100);
      check("err_seg_once", 32'(es_cnt - es0), 32'd1);
      check("err_seg_hold", 32'(digs()), 32'h0689);

      fd0 = fd_cnt;
      for (int k = 0; k < 6; k++)
         phase(4'b1011, (k % 2 == 0) ? {1'b1, 7'h79} : {1'b1, 7'h24}, 30);
      check("glitch_digit", 32'(bus.digit_2), 32'h6);
      check("glitch_frame", 32'(fd_cnt - fd0), 32'd0);
      phase(4'hF, 8'hFF, 100);

      phase(4'b1101, {1'b1, 7'h79}, 40);
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(bus.digit_valid), 32'h0);
      check("midrst_digits", 32'(digs()), 32'h0);
      repeat (2) @(posedge master_clk);
      #2 rst = 1'b0;
      phase(4'b1101, {1'b1, 7'h79}, S);
      check("post_rst_wait", 32'(bus.digit_valid), 32'h0);
      phase(4'b1101, {1'b1, 7'h79}, 1);
      check("post_rst_valid", 32'(bus.digit_valid), 32'h2);
      check("post_rst_digit", 32'(bus.digit_3), 32'h1);
      phase(4'hF, 8'hFF, 10);

      for (int n = 0; n < 300; n++) begin
         logic [3:0] a;
         logic [6:0] s;
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            a = 4'hF;
         end else if (r == 1) begin
            a = 4'($urandom);
            while ($countones(~a) < 2) a = 4'($urandom);
         end else begin
            a = ~(4'b0001 << $urandom_range(0, 3));
         end
         r = $urandom_range(0, 9);
         if (r < 7)       s = pat[$urandom_range(0, 9)];
         else if (r == 7) s = 7'h7F;
         else             s = 7'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            phase(a, {1'($urandom), s}, $urandom_range(1, 60));
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge master_clk);
            #2 rst = 1'b0;
         end
         phase(a, {1'($urandom), s}, $urandom_range(20, 150));
      end
      phase(4'hF, 8'hFF, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_capture.md
# display_capture

Receive-side counterpart of the seven-segment display driver: observes the multiplexed, active-low `seg`/`an` bus and reconstructs the four displayed digits, per-digit blank (blink-off) status and frame completion. Sits in the Nexys3 test harness beside the display driver for self-checking and feeds the game logic's display readback path. Filters anode/segment transitions (ghosting) with a stability counter before accepting a sample.

## Interface
- `STABLE_CYCLES`, 64: consecutive identical samples needed to accept a phase; legal range 2..1023.
- `master_clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `seg` in 8: segment bus, active-low; `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp (ignored for decode).
- `an` in 4: anode bus, active-low; `an[3]`→digit_1 (leftmost) … `an[0]`→digit_4.
- `digit_1`..`digit_4` out 4 each: last accepted value, 0–9.
- `digit_valid` out 4: bit i set once a legal digit captured for that position (bit 3 = digit_1); sticky until reset.
- `blank` out 4: bit set when the last accepted pattern for that position was all segments off.
- `frame_done` out 1: one-cycle pulse when all four positions have been accepted since the previous pulse.
- `err_anode` out 1: one-cycle pulse when a stable sample has more than one anode low.
- `err_seg` out 1: one-cycle pulse when a stable single-anode sample has an undecodable pattern.

## Operation
- Sample register `s_reg` = {an, seg} loaded every cycle; `cnt` (saturating at `STABLE_CYCLES`) cleared when input ≠ `s_reg`, else incremented.
- Accept event: `cnt == STABLE_CYCLES-1` and input == `s_reg`; fires exactly once per stable phase (cnt then saturates).
- On accept, classify `an`:
  - 4'hF (all off): no action, no error.
  - exactly one bit low: decode `seg[6:0]`.
  - two or more low: pulse `err_anode`; no output change.
- Decode (active-low, gfedcba): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, blank=7'h7F.
  - digit: write `digit_n`, set `digit_valid[n]`, clear `blank[n]`.
  - blank: set `blank[n]`, `digit_n` unchanged.
  - other: pulse `err_seg`; no output change.
- Frame tracking: 4-bit `seen` mask; set bit on each legal (digit or blank) accept. When the mask would become 4'hF, pulse `frame_done` and clear mask in the same cycle. Re-accepting an already-seen position has no extra effect.

## Timing
- Reset values: `digit_*`=0, `digit_valid`=0, `blank`=0, `frame_done`=0, `err_*`=0, `s_reg`={4'hF,8'hFF}, `cnt`=0, `seen`=0.
- Input first sampled at edge t0 and held: outputs/pulses update at edge t0+`STABLE_CYCLES`.
- Any input change before that restarts the count; phases shorter than `STABLE_CYCLES` cycles are never accepted.
- Pulses last exactly one cycle; `frame_done` and `err_*` are mutually exclusive in a cycle.
- `rst` asserted mid-phase: all state cleared immediately; after release the current phase needs a full `STABLE_CYCLES` again.
- `seg`/`an` are synchronous to `master_clk` (internal nets); no synchroniser.

## Structure
- Package `display_pkg`: active-low segment constants for 0–9 and blank, anode-to-position mapping, idle bus constant {4'hF,8'hFF}.
- Sub-module `seg7_decode`: combinational 7-bit pattern → {legal, is_blank, value[3:0]}; remainder (sampler, counter, capture, frame mask) in `display_capture`.

## Test plan
- Reset, then drive an=4'b0111, seg=8'hFF with 7'h19 in low bits (digit 4) for 64 cycles → `digit_1`=4, `digit_valid`=4'b1000 at cycle 64; not at 63.
- Cycle an through 0111/1011/1101/1110 with 4,6,8,9, 100 cycles each → digits 4,6,8,9, `frame_done` single pulse on fourth accept, `digit_valid`=4'hF.
- Hold an=4'b0111 with seg[6:0]=7'h7F → `blank`=4'b1000, `digit_1` retains prior value; then 7'h40 → `blank[3]` clears, `digit_1`=0.
- an=4'b0011 for 64 cycles → `err_anode` one pulse, no output change; seg[6:0]=7'h7E on single anode → `err_seg` one pulse.
- Glitch: toggle seg every 30 cycles with `STABLE_CYCLES`=64 → no accepts; `rst` asserted at cycle 40 of a valid phase → all outputs 0, capture only after 64 further stable cycles.
